muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with its own HI/LO register pair, sitting beside the ALU in the execute stage. It decodes the R-type multiply/divide/move group from `opcode`/`funct` (the ALU decoder never maps these), runs MULT/MULTU/DIV/DIVU as a radix-2 sequential datapath parametrised in width, and serves MFHI/MFLO/MTHI/MTLO in a single cycle. Requests use a valid/ready handshake; completion is signalled by a one-cycle `done` pulse.

## Interface
- `WIDTH`, 32, operand/HI/LO width; even, ≥ 4.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  request present this cycle.
- `ready_out`  out  1  unit can accept; high exactly when FSM is IDLE.
- `opcode`  in  6  instruction opcode; only RTYPE (6'h00) is legal.
- `funct`  in  6  MFHI 10, MTHI 11, MFLO 12, MTLO 13, MULT 18, MULTU 19, DIV 1A, DIVU 1B (hex).
- `rs_val`, `rt_val`  in  WIDTH each  operand A / operand B; MTHI/MTLO use `rs_val`.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO, registered.
- `rd_val`  out  WIDTH  MFHI/MFLO result.
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_val`.
- `done`  out  1  one-cycle pulse: mul/div result now in `hi`/`lo`.
- `div0`  out  1  with `done`, divisor was zero.
- `illegal`  out  1  one-cycle pulse: accepted request not in the group above.

## Operation
- Accept = `valid_in && ready_out` at a rising edge. No queue; `valid_in` while not ready is ignored, requester holds.
- FSM states: IDLE → RUN (accept of MULT/MULTU/DIV/DIVU) → FIX → IDLE. All other accepted requests complete in IDLE.
- MTHI/MTLO: `hi`/`lo` ← `rs_val` at the accept edge.
- MFHI/MFLO: `rd_val` ← `hi`/`lo` at the accept edge; `rd_valid` high the following cycle. MT then MF back-to-back returns the new value.
- Illegal opcode or funct: no state change; `illegal` high the following cycle.
- Signed ops: operand magnitudes latched at accept, signs recorded; unsigned ops latch raw operands.
- RUN: exactly WIDTH iterations, one bit per cycle. Multiply: shift-add into 2·WIDTH accumulator. Divide: restoring, one quotient bit per cycle.
- FIX: product negated if operand signs differ. Quotient negated if signs differ; remainder takes dividend sign. Writes `hi`/`lo` (product upper/lower; remainder/quotient).
- Divide by zero: `lo` = all ones, `hi` = `rs_val` as latched, `div0` = 1 with `done`.
- DIV MIN/−1: `lo` = MIN, `hi` = 0 (falls out of magnitude arithmetic; no special case needed).
- Width: all internal arithmetic is modulo 2^WIDTH (2^(2·WIDTH) for the accumulator); no exceptions.

## Timing
- Reset (async assert, sync-safe deassert by the system): state IDLE, `hi` = `lo` = `rd_val` = 0, `ready_out` = 1, `rd_valid` = `done` = `div0` = `illegal` = 0.
- Mul/div accepted at edge E0: RUN for cycles E0+1..E0+WIDTH, FIX during cycle E0+WIDTH+1. `hi`/`lo` are updated, `done` is high and `ready_out` is high in cycle E0+WIDTH+2. Latency is WIDTH+2 edges, with a new request acceptable in the same cycle as `done`.
- `hi`/`lo` hold their old values throughout RUN/FIX.
- Reset mid-operation aborts immediately: the partial result is discarded and `hi`/`lo` = 0.

## Structure
- Shared header `MulDiv.vh`: funct constants (MFHI..DIVU) and FSM state encodings; RTYPE comes from the existing `Opcode.vh`.
- One sub-module `muldiv_step`: combinational single iteration (add-shift or subtract-compare-shift), parametrised by WIDTH, selected by a mode bit.
- Top module holds the FSM, iteration counter ($clog2(WIDTH)+1 bits), operand/accumulator registers and HI/LO.

## Test plan
- MULTU `FFFFFFFF`×`FFFFFFFF` → `hi`=`FFFFFFFE`, `lo`=`00000001`, `done` exactly 34 cycles after accept; `ready_out` low in between.
- MULT −3×7 → `hi`=`FFFFFFFF`, `lo`=`FFFFFFEB`; DIV −7÷2 → `lo`=`FFFFFFFD`, `hi`=`FFFFFFFF`.
- DIVU 7÷0 → `lo`=`FFFFFFFF`, `hi`=7, `div0`=1; DIV `80000000`÷`FFFFFFFF` → `lo`=`80000000`, `hi`=0, `div0`=0.
- MTHI `00001234`, next cycle MFHI → `rd_val`=`00001234` with `rd_valid` one cycle later; MFLO held on `valid_in` during a DIV is accepted only in the `done` cycle.
- `reset_n` low in RUN iteration 10 → all outputs take reset values at once; after release, `ready_out`=1 and `hi`=`lo`=0.
- `opcode`=`23` (LW), and RTYPE with `funct`=`20` (ADD) → `illegal` pulse each; `hi`/`lo` unchanged.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_pkg
// Purpose  : Opcode/funct constants and FSM state encoding for muldiv_unit
// Revision : 1.0
// ============================================================================
package muldiv_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MTHI   = 6'h11;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MTLO   = 6'h13;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage : muldiv_unit_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One radix-2 iteration: shift-add multiply or restoring divide
// Revision : 1.0
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand_b,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand_b} : '0);
        trial = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        // When trial >= divisor the true difference is below the divisor, so W bits suffice
        diff  = trial[WIDTH-1:0] - operand_b;
        if (div_mode) begin
            if (trial >= {1'b0, operand_b}) begin
                acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit with HI/LO and single-cycle moves
// Revision : 1.0
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_val,
    output logic             rd_valid,
    output logic             done,
    output logic             div0,
    output logic             illegal
);

    localparam int             CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     rd_val_q, rd_val_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 done_q, done_d;
    logic                 div0_q, div0_d;
    logic                 illegal_q, illegal_d;

    logic [2*WIDTH-1:0]   step_acc;
    logic                 op_signed;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic                 div_by_zero;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode  (is_div_q),
        .acc_in    (acc_q),
        .operand_b (opb_q),
        .acc_out   (step_acc)
    );

    // MULT/DIV have funct[0] clear; their unsigned twins have it set
    assign op_signed   = ~funct[0];
    assign sign_a      = op_signed & rs_val[WIDTH-1];
    assign sign_b      = op_signed & rt_val[WIDTH-1];
    assign mag_a       = sign_a ? -rs_val : rs_val;
    assign mag_b       = sign_b ? -rt_val : rt_val;
    assign prod_fix    = neg_res_q ? -acc_q : acc_q;
    assign quo_fix     = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign div_by_zero = (opb_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_val_d   = rd_val_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        div0_d     = 1'b0;
        illegal_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (opcode != OP_RTYPE) begin
                        illegal_d = 1'b1;
                    end else begin
                        case (funct)
                            F_MFHI: begin
                                rd_val_d   = hi_q;
                                rd_valid_d = 1'b1;
                            end
                            F_MFLO: begin
                                rd_val_d   = lo_q;
                                rd_valid_d = 1'b1;
                            end
                            F_MTHI: hi_d = rs_val;
                            F_MTLO: lo_d = rs_val;
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                state_d   = ST_RUN;
                                cnt_d     = CNT_INIT;
                                is_div_d  = funct[1];
                                acc_d     = {{WIDTH{1'b0}}, mag_a};
                                opb_d     = mag_b;
                                neg_res_d = sign_a ^ sign_b;
                                neg_rem_d = sign_a;
                            end
                            default: illegal_d = 1'b1;
                        endcase
                    end
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Divisor zero leaves the dividend as remainder; only the quotient is forced
                    div0_d = div_by_zero;
                    lo_d   = div_by_zero ? '1 : quo_fix;
                    hi_d   = rem_fix;
                end else begin
                    lo_d   = prod_fix[WIDTH-1:0];
                    hi_d   = prod_fix[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_val_q   <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            div0_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_val_q   <= rd_val_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            div0_q     <= div0_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ready_out = (state_q == ST_IDLE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign rd_val    = rd_val_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign div0      = div0_q;
    assign illegal   = illegal_q;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed scoreboard bench for muldiv_unit
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         valid_in = 1'b0;
    logic [5:0]   opcode = '0;
    logic [5:0]   funct = '0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         ready_out;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rd_val;
    logic         rd_valid;
    logic         done;
    logic         div0;
    logic         illegal;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .opcode    (opcode),
        .funct     (funct),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .hi        (hi),
        .lo        (lo),
        .rd_val    (rd_val),
        .rd_valid  (rd_valid),
        .done      (done),
        .div0      (div0),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = done, 1 = rd_valid, 2 = illegal
    typedef struct {
        int           kind;
        int           edge_n;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int edge_n, input logic [W-1:0] h,
                        input logic [W-1:0] l, input logic d0, input string name);
        exp_t e;
        e.kind = kind; e.edge_n = edge_n; e.hi = h; e.lo = l; e.div0 = d0; e.name = name;
        sb.push_back(e);
    endtask

    // Drives a request and returns the edge count at which it was accepted
    task automatic send(input logic [5:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b, output int acc_edge);
        int n;
        n = 0;
        @(negedge clk);
        opcode = op; funct = fn; rs_val = a; rt_val = b; valid_in = 1'b1;
        while (!ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_out got 0 expected 1");
        end
        @(posedge clk);
        #1;
        acc_edge = cyc;
    endtask

    task automatic drop();
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic muldiv(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] h, input logic [W-1:0] l, input logic d0,
                          input string name);
        int e;
        send(OP_RTYPE, fn, a, b, e);
        push(0, e + W + 1, h, l, d0, name);
        drop();
    endtask

    // Monitor: pops the oldest expectation whenever the DUT presents a result
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (reset_n && (done || rd_valid || illegal)) begin
            k = done ? 0 : (rd_valid ? 1 : 2);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got done=%b rd_valid=%b illegal=%b expected none",
                         done, rd_valid, illegal);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_kind"}, k, e.kind);
                chk({e.name, "_edge"}, cyc, e.edge_n);
                case (e.kind)
                    0: begin
                        chk({e.name, "_hi"}, hi, e.hi);
                        chk({e.name, "_lo"}, lo, e.lo);
                        chk({e.name, "_div0"}, W'(div0), W'(e.div0));
                    end
                    1: chk({e.name, "_rd_val"}, rd_val, e.lo);
                    default: begin
                        chk({e.name, "_hi"}, hi, e.hi);
                        chk({e.name, "_lo"}, lo, e.lo);
                    end
                endcase
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e;
        int   e2;
        logic bad;

        repeat (3) @(negedge clk);
        chk("reset_ready", W'(ready_out), 1);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_rd_val", rd_val, 0);
        chk("reset_pulses", W'({rd_valid, done, div0, illegal}), 0);
        reset_n = 1'b1;

        send(6'h23, 6'h00, 32'h0000_0001, 32'h0000_0002, e);
        push(2, e, 32'h0, 32'h0, 1'b0, "illegal_lw");
        drop();

        send(OP_RTYPE, F_MTHI, 32'h0000_1234, 32'h0, e);
        send(OP_RTYPE, F_MFHI, 32'h0, 32'h0, e);
        push(1, e, 32'h0, 32'h0000_1234, 1'b0, "mfhi_after_mthi");
        drop();

        send(OP_RTYPE, F_MTLO, 32'h0000_5678, 32'h0, e);
        drop();
        send(OP_RTYPE, F_MFLO, 32'h0, 32'h0, e);
        push(1, e, 32'h0, 32'h0000_5678, 1'b0, "mflo_after_mtlo");
        drop();

        send(OP_RTYPE, 6'h20, 32'h0000_0003, 32'h0000_0004, e);
        push(2, e, 32'h0000_1234, 32'h0000_5678, 1'b0, "illegal_add");
        drop();

        // MULTU max*max, with ready_out watched low until done appears
        send(OP_RTYPE, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
        push(0, e + W + 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        drop();
        bad = 1'b0;
        for (int i = 0; i < W + 1; i++) begin
            if (ready_out || hi !== 32'h0000_1234) bad = 1'b1;
            @(negedge clk);
        end
        chk("multu_busy_hold", W'(bad), 0);
        chk("multu_ready_with_done", W'({ready_out, done}), 3);

        muldiv(F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg3x7");
        muldiv(F_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7by2");
        muldiv(F_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, "divu_by0");
        muldiv(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_min_by_m1");
        muldiv(F_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, "divu_100by7");

        // MFLO held on valid_in through a DIV is taken the edge after done
        send(OP_RTYPE, F_DIV, 32'h0000_0064, 32'hFFFF_FFF9, e);
        push(0, e + W + 1, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, "div_100bym7");
        send(OP_RTYPE, F_MFLO, 32'h0, 32'h0, e2);
        chk("mflo_held_accept_edge", e2 - e, W + 2);
        push(1, e2, 32'h0, 32'hFFFF_FFF2, 1'b0, "mflo_held");
        drop();
        repeat (3) @(negedge clk);

        // Reset asserted while iteration 10 is in flight
        send(OP_RTYPE, F_DIVU, 32'h0000_03E8, 32'h0000_0003, e);
        drop();
        repeat (9) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_ready", W'(ready_out), 1);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_rd_val", rd_val, 0);
        chk("abort_pulses", W'({rd_valid, done, div0, illegal}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_ready", W'(ready_out), 1);
        chk("post_reset_hilo", {hi[15:0], lo[15:0]}, 0);

        send(OP_RTYPE, F_MFHI, 32'h0, 32'h0, e);
        push(1, e, 32'h0, 32'h0, 1'b0, "mfhi_post_reset");
        drop();
        repeat (W + 4) @(negedge clk);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
